// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: RUN/PAUSED/ADJUST sequencing, count and adjust strobes,
// blink-driven digit blanking and a free-running display scan strobe.
module stopwatch_ctrl #(
   parameter int SEC_DIV   = 100000000,
   parameter int ADJ_DIV   = 50000000,
   parameter int BLINK_DIV = 25000000,
   parameter int SCAN_DIV  = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause_p,
   input  logic       clr_p,
   input  logic       sel,
   input  logic       adj,
   output logic [1:0] state,
   output logic       inc_p,
   output logic       adj_inc_p,
   output logic       adj_sel,
   output logic       clear_p,
   output logic       blank_min,
   output logic       blank_sec,
   output logic       scan_p
);

   localparam int SW  = (SEC_DIV   > 1) ? $clog2(SEC_DIV)   : 1;
   localparam int AW  = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
   localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int SCW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_PAUSED = 2'b01,
      ST_ADJUST = 2'b10
   } state_t;

   state_t         state_q, state_d;
   logic           resume_q, resume_d;   // 1: leave ADJUST back into PAUSED
   logic [SW-1:0]  sec_cnt_q, sec_cnt_d;
   logic [AW-1:0]  adj_cnt_q, adj_cnt_d;
   logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic           phase_q, phase_d;
   logic           inc_p_q, inc_p_d;
   logic           adj_inc_p_q, adj_inc_p_d;
   logic           adj_sel_q, adj_sel_d;
   logic           clear_p_q, clear_p_d;
   logic           blank_min_q, blank_min_d;
   logic           blank_sec_q, blank_sec_d;
   logic           scan_p_q, scan_p_d;

   logic in_run, in_adj, sec_wrap, adj_wrap, blink_wrap, scan_wrap;

   assign in_run     = (state_q == ST_RUN);
   assign in_adj     = (state_q == ST_ADJUST);
   assign sec_wrap   = in_run && (sec_cnt_q == SW'(SEC_DIV - 1));
   assign adj_wrap   = in_adj && (adj_cnt_q == AW'(ADJ_DIV - 1));
   assign blink_wrap = (blink_cnt_q == BW'(BLINK_DIV - 1));
   assign scan_wrap  = (scan_cnt_q == SCW'(SCAN_DIV - 1));

   // Adjust request outranks pause; pause is ignored while adjusting.
   always_comb begin
      state_d  = state_q;
      resume_d = resume_q;
      case (state_q)
         ST_RUN, ST_PAUSED: begin
            if (adj) begin
               state_d  = ST_ADJUST;
               resume_d = (state_q == ST_PAUSED);
            end else if (pause_p) begin
               state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
            end
         end
         ST_ADJUST: begin
            if (!adj) state_d = resume_q ? ST_PAUSED : ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      sec_cnt_d   = sec_cnt_q;
      inc_p_d     = sec_wrap && !clr_p;
      clear_p_d   = clr_p;
      if (clr_p || sec_wrap) sec_cnt_d = '0;
      else if (in_run)       sec_cnt_d = sec_cnt_q + SW'(1);

      adj_cnt_d   = (!in_adj || adj_wrap) ? '0 : adj_cnt_q + AW'(1);
      adj_inc_p_d = adj_wrap;

      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
      phase_d     = phase_q ^ blink_wrap;
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCW'(1);
      scan_p_d    = scan_wrap;

      // Blanks are built from next-cycle values so the registered outputs
      // line up with the registered state, phase and adj_sel.
      adj_sel_d   = sel;
      blank_min_d = phase_d && (((state_d == ST_ADJUST) && !sel) || (state_d == ST_PAUSED));
      blank_sec_d = phase_d && (((state_d == ST_ADJUST) &&  sel) || (state_d == ST_PAUSED));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         resume_q    <= 1'b0;
         sec_cnt_q   <= '0;
         adj_cnt_q   <= '0;
         blink_cnt_q <= '0;
         scan_cnt_q  <= '0;
         phase_q     <= 1'b0;
         inc_p_q     <= 1'b0;
         adj_inc_p_q <= 1'b0;
         adj_sel_q   <= 1'b0;
         clear_p_q   <= 1'b0;
         blank_min_q <= 1'b0;
         blank_sec_q <= 1'b0;
         scan_p_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         resume_q    <= resume_d;
         sec_cnt_q   <= sec_cnt_d;
         adj_cnt_q   <= adj_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         scan_cnt_q  <= scan_cnt_d;
         phase_q     <= phase_d;
         inc_p_q     <= inc_p_d;
         adj_inc_p_q <= adj_inc_p_d;
         adj_sel_q   <= adj_sel_d;
         clear_p_q   <= clear_p_d;
         blank_min_q <= blank_min_d;
         blank_sec_q <= blank_sec_d;
         scan_p_q    <= scan_p_d;
      end
   end

   assign state     = state_q;
   assign inc_p     = inc_p_q;
   assign adj_inc_p = adj_inc_p_q;
   assign adj_sel   = adj_sel_q;
   assign clear_p   = clear_p_q;
   assign blank_min = blank_min_q;
   assign blank_sec = blank_sec_q;
   assign scan_p    = scan_p_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random traffic, each cycle
// checked against an elapsed-count reference model.
module tb_stopwatch_ctrl;

   localparam int SEC_DIV   = 10;
   localparam int ADJ_DIV   = 4;
   localparam int BLINK_DIV = 3;
   localparam int SCAN_DIV  = 2;

   logic       clk = 1'b0;
   logic       rst, pause_p, clr_p, sel, adj;
   logic [1:0] state;
   logic       inc_p, adj_inc_p, adj_sel, clear_p, blank_min, blank_sec, scan_p;

   stopwatch_ctrl #(
      .SEC_DIV(SEC_DIV), .ADJ_DIV(ADJ_DIV), .BLINK_DIV(BLINK_DIV), .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk(clk), .rst(rst), .pause_p(pause_p), .clr_p(clr_p), .sel(sel), .adj(adj),
      .state(state), .inc_p(inc_p), .adj_inc_p(adj_inc_p), .adj_sel(adj_sel),
      .clear_p(clear_p), .blank_min(blank_min), .blank_sec(blank_sec), .scan_p(scan_p)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: mode is 0 RUN, 1 PAUSED, 2 ADJUST; timing is derived
   // from elapsed cycle counts rather than from wrapping counters.
   int   m_mode, m_resume, run_ticks, adj_ticks, t;
   logic e_inc, e_adj_inc, e_clear, e_sel, e_bmin, e_bsec, e_scan;
   int   inc_hits, last_inc_t;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic p, input logic c,
                             input logic s, input logic a);
      int phase;
      if (r) begin
         m_mode = 0; m_resume = 0; run_ticks = 0; adj_ticks = 0; t = 0;
         e_inc = 0; e_adj_inc = 0; e_clear = 0; e_sel = 0;
         e_bmin = 0; e_bsec = 0; e_scan = 0;
      end else begin
         t++;
         e_inc     = (m_mode == 0) && !c && (((run_ticks + 1) % SEC_DIV) == 0);
         if (c) run_ticks = 0;
         else if (m_mode == 0) run_ticks++;
         e_adj_inc = (m_mode == 2) && (((adj_ticks + 1) % ADJ_DIV) == 0);
         adj_ticks = (m_mode == 2) ? adj_ticks + 1 : 0;
         e_clear   = c;
         e_sel     = s;
         if (m_mode != 2) begin
            if (a) begin
               m_resume = m_mode;
               m_mode   = 2;
            end else if (p) begin
               m_mode = 1 - m_mode;
            end
         end else if (!a) begin
            m_mode = m_resume;
         end
         phase  = (t / BLINK_DIV) % 2;
         e_scan = ((t % SCAN_DIV) == 0);
         e_bmin = (phase == 1) && ((m_mode == 1) || (m_mode == 2 && !e_sel));
         e_bsec = (phase == 1) && ((m_mode == 1) || (m_mode == 2 &&  e_sel));
      end
   endtask

   task automatic check_all();
      check("state",     8'(state),     8'(m_mode));
      check("inc_p",     8'(inc_p),     8'(e_inc));
      check("adj_inc_p", 8'(adj_inc_p), 8'(e_adj_inc));
      check("adj_sel",   8'(adj_sel),   8'(e_sel));
      check("clear_p",   8'(clear_p),   8'(e_clear));
      check("blank_min", 8'(blank_min), 8'(e_bmin));
      check("blank_sec", 8'(blank_sec), 8'(e_bsec));
      check("scan_p",    8'(scan_p),    8'(e_scan));
      check("inc_excl",  8'(inc_p & adj_inc_p), 8'd0);
   endtask

   task automatic step(input logic r, input logic p, input logic c,
                       input logic s, input logic a);
      rst = r; pause_p = p; clr_p = c; sel = s; adj = a;
      @(posedge clk);
      model_edge(r, p, c, s, a);
      #1;
      check_all();
      if (inc_p) begin
         inc_hits++;
         last_inc_t = t;
      end
      pause_p = 1'b0;
      clr_p   = 1'b0;
   endtask

   initial begin
      int n, mask, hits0, any_bmin;
      logic r_r, r_p, r_c, r_s, r_a;
      rst = 1'b1; pause_p = 1'b0; clr_p = 1'b0; sel = 1'b0; adj = 1'b0;
      inc_hits = 0; last_inc_t = 0;

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("reset_state", 8'(state), 8'd0);

      // Idle run after reset: count strobes on cycles 10, 20, 30, 40.
      inc_hits = 0;
      repeat (40) step(0, 0, 0, 0, 0);
      check("inc_hits_40", 8'(inc_hits), 8'd4);
      check("last_inc_40", 8'(last_inc_t), 8'd40);

      // Pause gap then resume.
      repeat (5) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check("paused", 8'(state), 8'd1);
      hits0 = inc_hits;
      repeat (20) step(0, 0, 0, 0, 0);
      check("gap_no_inc", 8'(inc_hits - hits0), 8'd0);
      step(0, 1, 0, 0, 0);
      n = 1;
      while (!inc_p && n < 20) begin
         step(0, 0, 0, 0, 0);
         n++;
      end
      check("resume_to_inc", 8'(n), 8'd5);

      // Adjust seconds from PAUSED.
      step(0, 1, 0, 0, 0);
      check("paused2", 8'(state), 8'd1);
      mask = 0; any_bmin = 0;
      for (int k = 1; k <= 13; k++) begin
         step(0, 0, 0, 1, 1);
         if (adj_inc_p && k <= 12) mask |= (1 << k);
         any_bmin |= int'(blank_min);
      end
      check("adj_state", 8'(state), 8'd2);
      check("adj_pulses", 8'(mask >> 4), 8'h22);
      check("adj_bmin0", 8'(any_bmin), 8'd0);
      step(0, 0, 0, 1, 0);
      check("adj_back_paused", 8'(state), 8'd1);

      // Pause ignored in ADJUST; resume flag keeps RUN.
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("adj_ignore_pause", 8'(state), 8'd2);
      step(0, 0, 0, 0, 0);
      check("adj_back_run", 8'(state), 8'd0);

      // Clear together with pause at prescaler count 9.
      step(1, 0, 0, 0, 0);
      repeat (9) step(0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      check("clr_clear_p", 8'(clear_p), 8'd1);
      check("clr_no_inc", 8'(inc_p), 8'd0);
      check("clr_state", 8'(state), 8'd1);
      step(0, 0, 0, 0, 0);
      check("clr_once", 8'(clear_p), 8'd0);
      step(0, 1, 0, 0, 0);
      n = 1;
      while (!inc_p && n < 30) begin
         step(0, 0, 0, 0, 0);
         n++;
      end
      check("clr_zeroed", 8'(n), 8'd11);

      // Reset mid-ADJUST overrides every input.
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(1, 1, 1, 1, 1);
      check("rst_state", 8'(state), 8'd0);
      check("rst_outs", 8'({inc_p, adj_inc_p, adj_sel, clear_p, blank_min, blank_sec, scan_p}), 8'd0);
      n = 0;
      do begin
         step(0, 0, 0, 0, 0);
         n++;
      end while (!inc_p && n < 30);
      check("rst_to_inc", 8'(n), 8'd10);

      // Random traffic.
      r_s = 1'b0; r_a = 1'b0;
      for (int i = 0; i < 600; i++) begin
         r_r = ($urandom_range(0, 149) == 0);
         r_p = ($urandom_range(0, 7) == 0);
         r_c = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 5) == 0) r_s = ~r_s;
         if ($urandom_range(0, 12) == 0) r_a = ~r_a;
         step(r_r, r_p, r_c, r_s, r_a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
